// File: rtl/pwm_gen_multi.sv
// Multi-channel PWM generator with shadowed high/low counts, reloaded at period boundaries.
// Define PWM_ONESHOT_EN to add cfg_oneshot: a oneshot channel runs one period then disarms.
module pwm_gen_multi #(
    parameter int NCH   = 4,
    parameter int CNT_W = 26,
    parameter int CH_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk0,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic             cfg_en,
    input  logic [CNT_W-1:0] cfg_high,
    input  logic [CNT_W-1:0] cfg_low,
`ifdef PWM_ONESHOT_EN
    input  logic             cfg_oneshot,
`endif
    output logic [NCH-1:0]   pwm_out,
    output logic [NCH-1:0]   period_done,
    output logic [NCH-1:0]   busy
);

    // state | meaning
    // IDLE  | output low, waiting for enable and a non-zero high/low pair
    // HIGH  | output high, cnt = cycles left after the current one
    // LOW   | output low,  cnt = cycles left after the current one
    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        state_t           st, st_nx;
        logic             en, en_nx, wr, eff_os;
        logic [CNT_W-1:0] sh_h, sh_l, act_h, act_l, cnt;
        logic [CNT_W-1:0] act_h_nx, act_l_nx, cnt_nx, src_h, src_l;
        logic             pwm_q, done_q, busy_q, pwm_nx, done_nx, ld, bnd;

        assign wr = cfg_we && (32'(cfg_ch) == i);

`ifdef PWM_ONESHOT_EN
        logic os;
        always_ff @(posedge clk0 or negedge rst_n) begin
            if (!rst_n)  os <= 1'b0;
            else if (wr) os <= cfg_oneshot;
        end
        assign eff_os = os;
`else
        assign eff_os = 1'b0;
`endif

        always_comb begin
            st_nx    = st;
            en_nx    = en;
            cnt_nx   = cnt;
            act_h_nx = act_h;
            act_l_nx = act_l;
            pwm_nx   = pwm_q;
            done_nx  = 1'b0;
            ld       = 1'b0;
            bnd      = 1'b0;
            // A write landing on the boundary cycle bypasses the shadow.
            src_h    = wr ? cfg_high : sh_h;
            src_l    = wr ? cfg_low  : sh_l;
            case (st)
                IDLE: begin
                    pwm_nx = 1'b0;
                    if (en && (|{sh_h, sh_l})) begin
                        ld    = 1'b1;
                        src_h = sh_h;
                        src_l = sh_l;
                    end
                end
                HIGH: begin
                    if (cnt != '0) begin
                        cnt_nx  = cnt - CNT_W'(1);
                        done_nx = (act_l == '0) && (cnt == CNT_W'(1));
                    end else if (act_l != '0) begin
                        st_nx   = LOW;
                        pwm_nx  = 1'b0;
                        cnt_nx  = act_l - CNT_W'(1);
                        done_nx = (act_l == CNT_W'(1));
                    end else begin
                        bnd = 1'b1;
                    end
                end
                LOW: begin
                    if (cnt != '0) begin
                        cnt_nx  = cnt - CNT_W'(1);
                        done_nx = (cnt == CNT_W'(1));
                    end else begin
                        bnd = 1'b1;
                    end
                end
                default: st_nx = IDLE;
            endcase

            if (bnd) begin
                if (eff_os) begin
                    st_nx  = IDLE;
                    pwm_nx = 1'b0;
                    cnt_nx = '0;
                    en_nx  = 1'b0;
                end else begin
                    ld = 1'b1;
                end
            end

            if (ld) begin
                act_h_nx = src_h;
                act_l_nx = src_l;
                if (src_h != '0) begin
                    st_nx   = HIGH;
                    pwm_nx  = 1'b1;
                    cnt_nx  = src_h - CNT_W'(1);
                    done_nx = (src_l == '0) && (src_h == CNT_W'(1));
                end else if (src_l != '0) begin
                    st_nx   = LOW;
                    pwm_nx  = 1'b0;
                    cnt_nx  = src_l - CNT_W'(1);
                    done_nx = (src_l == CNT_W'(1));
                end else begin
                    st_nx   = IDLE;
                    pwm_nx  = 1'b0;
                    cnt_nx  = '0;
                    done_nx = 1'b0;
                end
            end

            if (wr) begin
                en_nx = cfg_en;
                if (!cfg_en) begin
                    st_nx   = IDLE;
                    pwm_nx  = 1'b0;
                    cnt_nx  = '0;
                    done_nx = 1'b0;
                end
            end
        end

        always_ff @(posedge clk0 or negedge rst_n) begin
            if (!rst_n) begin
                st     <= IDLE;
                en     <= 1'b0;
                sh_h   <= '0;
                sh_l   <= '0;
                act_h  <= '0;
                act_l  <= '0;
                cnt    <= '0;
                pwm_q  <= 1'b0;
                done_q <= 1'b0;
                busy_q <= 1'b0;
            end else begin
                st     <= st_nx;
                en     <= en_nx;
                act_h  <= act_h_nx;
                act_l  <= act_l_nx;
                cnt    <= cnt_nx;
                pwm_q  <= pwm_nx;
                done_q <= done_nx;
                busy_q <= (st_nx != IDLE);
                if (wr) begin
                    sh_h <= cfg_high;
                    sh_l <= cfg_low;
                end
            end
        end

        assign pwm_out[i]     = pwm_q;
        assign period_done[i] = done_q;
        assign busy[i]        = busy_q;
    end

endmodule

// File: tb/tb_pwm_gen_multi.sv
// Directed bench for pwm_gen_multi: an arithmetic per-channel waveform model
// fills a scoreboard queue that is drained cycle by cycle against the outputs.
module tb_pwm_gen_multi;
    localparam int NCH   = 4;
    localparam int CNT_W = 26;
    localparam int CH_W  = 3;   // wide enough to address out-of-range channels

    logic             clk0 = 1'b0;
    logic             rst_n = 1'b0;
    logic             cfg_we = 1'b0;
    logic [CH_W-1:0]  cfg_ch = '0;
    logic             cfg_en = 1'b0;
    logic [CNT_W-1:0] cfg_high = '0;
    logic [CNT_W-1:0] cfg_low = '0;
`ifdef PWM_ONESHOT_EN
    logic             cfg_oneshot = 1'b0;
`endif
    logic [NCH-1:0]   pwm_out, period_done, busy;

    pwm_gen_multi #(.NCH(NCH), .CNT_W(CNT_W), .CH_W(CH_W)) dut (
        .clk0(clk0), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_en(cfg_en), .cfg_high(cfg_high), .cfg_low(cfg_low),
`ifdef PWM_ONESHOT_EN
        .cfg_oneshot(cfg_oneshot),
`endif
        .pwm_out(pwm_out), .period_done(period_done), .busy(busy)
    );

    always #10 clk0 = ~clk0;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Model: a running channel with (h,l) started at t0 is periodic in h+l.
    bit run [NCH];
    int mh [NCH], ml [NCH], mt0 [NCH];
    bit pend [NCH];
    int ph [NCH], pl [NCH], pt0 [NCH];

    typedef struct packed {
        logic [NCH-1:0] pwm;
        logic [NCH-1:0] done;
        logic [NCH-1:0] bsy;
    } exp_t;
    exp_t sb [$];

    task automatic params_at(input int ch, input int c, output bit r,
                             output int h, output int l, output int t0);
        r = run[ch];
        if (pend[ch] && c >= pt0[ch]) begin
            h = ph[ch]; l = pl[ch]; t0 = pt0[ch];
        end else begin
            h = mh[ch]; l = ml[ch]; t0 = mt0[ch];
        end
    endtask

    task automatic expect_at(input int c, output exp_t e);
        bit r;
        int h, l, t0, p;
        e = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            params_at(ch, c, r, h, l, t0);
            if (r && (h + l) > 0 && c >= t0) begin
                p = (c - t0) % (h + l);
                e.pwm[ch]  = (p < h);
                e.done[ch] = (p == h + l - 1);
                e.bsy[ch]  = 1'b1;
            end
        end
    endtask

    task automatic is_start(input int ch, input int c, output bit s);
        bit r;
        int h, l, t0;
        params_at(ch, c, r, h, l, t0);
        s = r && (h + l) > 0 && c >= t0 && ((c - t0) % (h + l)) == 0;
    endtask

    task automatic model_write(input int ch, input bit en, input int h, input int l, input int k);
        int per, m;
        if (ch >= NCH) return;
        if (pend[ch] && pt0[ch] <= k) begin
            mh[ch] = ph[ch]; ml[ch] = pl[ch]; mt0[ch] = pt0[ch]; pend[ch] = 0;
        end
        if (!en) begin
            run[ch] = 0; pend[ch] = 0;
        end else if (!run[ch] || (mh[ch] + ml[ch]) == 0) begin
            run[ch] = 1; mh[ch] = h; ml[ch] = l; mt0[ch] = k + 1; pend[ch] = 0;
        end else begin
            per = mh[ch] + ml[ch];
            m = (k - mt0[ch] + per - 1) / per;
            pt0[ch] = mt0[ch] + m * per;
            ph[ch] = h; pl[ch] = l; pend[ch] = 1;
        end
    endtask

    task automatic model_reset();
        for (int ch = 0; ch < NCH; ch++) begin
            run[ch] = 0; pend[ch] = 0; mh[ch] = 0; ml[ch] = 0; mt0[ch] = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk0);
        cyc++;
        #1;
    endtask

    task automatic write(input int ch, input bit en, input int h, input int l);
        cfg_ch   = CH_W'(ch);
        cfg_en   = en;
        cfg_high = CNT_W'(h);
        cfg_low  = CNT_W'(l);
        cfg_we   = 1'b1;
        tick();
        model_write(ch, en, h, l, cyc);
        cfg_we   = 1'b0;
    endtask

    task automatic run_chk(input int n, input string tag);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            expect_at(cyc + 1 + i, e);
            sb.push_back(e);
        end
        for (int i = 0; i < n; i++) begin
            tick();
            e = sb.pop_front();
            checks++;
            assert ({pwm_out, period_done, busy} === e)
            else begin
                errors++;
                $error("FAIL %s cyc=%0d got pwm=%b done=%b busy=%b exp pwm=%b done=%b busy=%b",
                       tag, cyc, pwm_out, period_done, busy, e.pwm, e.done, e.bsy);
            end
        end
    endtask

    task automatic chk_zero(input string tag);
        checks++;
        assert ({pwm_out, period_done, busy} === '0)
        else begin
            errors++;
            $error("FAIL %s got pwm=%b done=%b busy=%b exp all zero",
                   tag, pwm_out, period_done, busy);
        end
    endtask

    initial begin
        bit s;
        model_reset();
        #1;
        chk_zero("reset_async");
        tick();
        tick();
        rst_n = 1'b1;
        run_chk(3, "reset_idle");

        // Reset while ch0 is running
        write(0, 1, 3, 5);
        run_chk(13, "pre_reset_run");
        #5 rst_n = 1'b0;
        #1;
        chk_zero("reset_midrun_async");
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
        run_chk(10, "post_reset_idle");

        // Basic pattern 11100000
        write(0, 1, 3, 5);
        run_chk(24, "basic_3_5");

        // Shadow write mid-HIGH, then a write landing on a boundary
        write(1, 1, 2, 2);
        run_chk(1, "shadow_start");
        write(1, 1, 4, 1);
        run_chk(16, "shadow_mid_high");
        s = 0;
        for (int g = 0; g < 40 && !s; g++) begin
            is_start(1, cyc + 1, s);
            if (!s) run_chk(1, "shadow_align");
        end
        write(1, 1, 1, 2);
        run_chk(12, "shadow_on_boundary");

        // Edge duties on ch2
        write(2, 1, 0, 4);
        run_chk(12, "h0_l4");
        write(2, 1, 6, 0);
        run_chk(20, "h6_l0");
        write(2, 1, 0, 0);
        run_chk(14, "h0_l0");

        // Independence, disable mid-HIGH, out-of-range channel
        write(2, 1, 2, 3);
        write(3, 1, 5, 2);
        run_chk(3, "indep_run");
        write(3, 0, 5, 2);
        run_chk(20, "disable_ch3");
        write(5, 1, 9, 9);
        write(4, 0, 1, 1);
        run_chk(16, "oob_channel");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
